// File: rtl/nn_pkg.sv
// nn_pkg: shared class count, default score width and accumulator FSM state type
package nn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int DEF_SCORE_W = 26;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
endpackage

// File: rtl/score_accumulator_if.sv
// score_accumulator_if: image bus; master drives start/in_valid/in_data/in_wt, slave returns in_ready/score/score_valid/busy
interface score_accumulator_if import nn_pkg::*; #(
  parameter int IN_W    = 8,
  parameter int WT_W    = 8,
  parameter int SCORE_W = DEF_SCORE_W
);
  logic start;
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] in_data;
  logic [NUM_CLASSES*WT_W-1:0] in_wt;
  logic [NUM_CLASSES*SCORE_W-1:0] score;
  logic score_valid;
  logic busy;
  modport master (output start, in_valid, in_data, in_wt, input in_ready, score, score_valid, busy);
  modport slave (input start, in_valid, in_data, in_wt, output in_ready, score, score_valid, busy);
endinterface

// File: rtl/mac_lane.sv
// mac_lane: signed multiply-accumulate (clk, rst, clr, en, a_i, w_i -> acc_o), saturating when SCORE_SAT_EN is defined
module mac_lane import nn_pkg::*; #(
  parameter int IN_W    = 8,
  parameter int WT_W    = 8,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [IN_W-1:0]    a_i,
  input  logic signed [WT_W-1:0]    w_i,
  output logic signed [SCORE_W-1:0] acc_o
);
  logic signed [IN_W+WT_W-1:0] prod;
  logic signed [SCORE_W-1:0] pext, acc_q, acc_d;
  assign prod = (IN_W+WT_W)'(a_i) * (IN_W+WT_W)'(w_i);
  assign pext = SCORE_W'(prod);
`ifdef SCORE_SAT_EN
  logic signed [SCORE_W:0] sum;
  assign sum = (SCORE_W+1)'(acc_q) + (SCORE_W+1)'(pext);
  assign acc_d = sum[SCORE_W] == sum[SCORE_W-1] ? sum[SCORE_W-1:0] : {sum[SCORE_W], {(SCORE_W-1){~sum[SCORE_W]}}};
`else
  assign acc_d = acc_q + pext;
`endif
  always_ff @(posedge clk) acc_q <= rst || clr ? '0 : en ? acc_d : acc_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/score_accumulator.sv
// score_accumulator: accumulates N_IN activations x ten class weights into ten scores (clk, rst, bus.slave); SCORE_SAT_EN selects saturation
module score_accumulator import nn_pkg::*; #(
  parameter int N_IN    = 64,
  parameter int IN_W    = 8,
  parameter int WT_W    = 8,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input logic clk,
  input logic rst,
  score_accumulator_if.slave bus
);
  localparam int CW = $clog2(N_IN+1);
  acc_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic in_ready_q, busy_q, score_valid_q, clr, en;
  logic [NUM_CLASSES*SCORE_W-1:0] score;
  assign clr = state_q == IDLE && bus.start;
  assign en = in_ready_q && bus.in_valid;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      score_valid_q <= 1'b0;
    end else case (state_q)
      IDLE: if (bus.start) begin
        state_q <= ACCUM;
        cnt_q <= '0;
        in_ready_q <= 1'b1;
        busy_q <= 1'b1;
      end
      ACCUM: if (bus.in_valid) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(N_IN-1)) begin
          state_q <= DONE;
          in_ready_q <= 1'b0;
          busy_q <= 1'b0;
          score_valid_q <= 1'b1;
        end
      end
      default: begin
        state_q <= IDLE;
        score_valid_q <= 1'b0;
      end
    endcase
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    mac_lane #(.IN_W(IN_W), .WT_W(WT_W), .SCORE_W(SCORE_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en(en),
      .a_i(bus.in_data),
      .w_i(bus.in_wt[k*WT_W +: WT_W]),
      .acc_o(score[k*SCORE_W +: SCORE_W])
    );
  end
  assign bus.score = score;
  assign bus.in_ready = in_ready_q;
  assign bus.busy = busy_q;
  assign bus.score_valid = score_valid_q;
endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: randomized and directed checks of score_accumulator against a behavioural model
module tb_score_accumulator;
  import nn_pkg::*;
  localparam int N_IN = 4;
  localparam int IN_W = 8;
  localparam int WT_W = 8;
  localparam int SW = 16;
  localparam int WW = NUM_CLASSES*WT_W;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int exp_s[NUM_CLASSES];
  bit m_act, m_sv, chk_en;
  int m_cnt;
  always #5 clk = ~clk;
  score_accumulator_if #(.IN_W(IN_W), .WT_W(WT_W), .SCORE_W(SW)) bus ();
  score_accumulator #(.N_IN(N_IN), .IN_W(IN_W), .WT_W(WT_W), .SCORE_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic int fold(input int v);
`ifdef SCORE_SAT_EN
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
    logic [SW-1:0] t;
    t = v[SW-1:0];
    return int'($signed(t));
`endif
  endfunction
  function automatic int dut_score(input int k);
    logic signed [SW-1:0] t;
    t = bus.score[k*SW +: SW];
    return int'(t);
  endfunction
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask
  initial begin
    chk_en = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act = 1'b0;
        m_sv = 1'b0;
        m_cnt = 0;
        foreach (exp_s[k]) exp_s[k] = 0;
        chk_en = 1'b1;
      end else if (m_sv) m_sv = 1'b0;
      else if (!m_act) begin
        if (bus.start) begin
          m_act = 1'b1;
          m_cnt = 0;
          foreach (exp_s[k]) exp_s[k] = 0;
        end
      end else if (bus.in_valid) begin
        foreach (exp_s[k]) begin
          logic signed [WT_W-1:0] w;
          w = bus.in_wt[k*WT_W +: WT_W];
          exp_s[k] = fold(exp_s[k] + int'(bus.in_data) * int'(w));
        end
        m_cnt++;
        if (m_cnt == N_IN) begin
          m_act = 1'b0;
          m_sv = 1'b1;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", int'(bus.in_ready), int'(m_act));
      chk("busy", int'(bus.busy), int'(m_act));
      chk("score_valid", int'(bus.score_valid), int'(m_sv));
      for (int k = 0; k < NUM_CLASSES; k++) chk($sformatf("score%0d", k), dut_score(k), exp_s[k]);
    end
  end
  task automatic setin(input bit s, input bit v, input logic signed [IN_W-1:0] d, input logic [WW-1:0] w);
    @(posedge clk);
    #2;
    bus.start = s;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_wt = w;
  endtask
  function automatic logic [WW-1:0] rand_w();
    logic [WW-1:0] w;
    for (int k = 0; k < NUM_CLASSES; k++) w[k*WT_W +: WT_W] = WT_W'($urandom);
    return w;
  endfunction
  function automatic logic [WW-1:0] all_w(input logic [WT_W-1:0] v);
    return {NUM_CLASSES{v}};
  endfunction
  task automatic image(input logic signed [IN_W-1:0] d, input logic [WW-1:0] w, input int gap, input bit rnd);
    setin(1'b1, 1'b0, '0, '0);
    for (int b = 0; b < N_IN; b++) begin
      for (int g = 0; g < gap; g++) setin(rnd ? 1'($urandom) : 1'b1, 1'b0, IN_W'($urandom), rand_w());
      setin(1'b0, 1'b1, rnd ? IN_W'($urandom) : d, rnd ? rand_w() : w);
    end
    setin(1'b0, 1'b0, '0, '0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [WW-1:0] w;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_wt = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ready", int'(bus.in_ready), 0);
    chk("reset_score0", dut_score(0), 0);
    image(8'sd1, all_w(8'd1), 0, 1'b0);
    @(negedge clk);
    chk("ones_valid", int'(bus.score_valid), 1);
    for (int k = 0; k < NUM_CLASSES; k++) chk($sformatf("ones_score%0d", k), dut_score(k), 4);
    repeat (3) setin(1'b0, 1'b1, 8'sd9, all_w(8'd9));
    w = '0;
    w[7*WT_W +: WT_W] = 8'd5;
    image(-8'sd3, w, 2, 1'b0);
    @(negedge clk);
    chk("gap_valid", int'(bus.score_valid), 1);
    chk("gap_score7", dut_score(7), -60);
    chk("gap_score0", dut_score(0), 0);
    setin(1'b0, 1'b0, '0, '0);
    image(8'sd127, all_w(8'd127), 0, 1'b0);
    @(negedge clk);
`ifdef SCORE_SAT_EN
    chk("ovf_score3", dut_score(3), 32767);
`else
    chk("ovf_score3", dut_score(3), -1020);
`endif
    setin(1'b1, 1'b0, '0, '0);
    setin(1'b0, 1'b1, 8'sd5, all_w(8'd1));
    setin(1'b0, 1'b1, 8'sd5, all_w(8'd1));
    @(posedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(bus.score_valid), 0);
    chk("rst_score5", dut_score(5), 0);
    image(8'sd2, all_w(8'd3), 1, 1'b0);
    @(negedge clk);
    chk("fresh_score9", dut_score(9), 24);
    w = '0;
    w[0 +: WT_W] = 8'd1;
    image(8'sd2, w, 0, 1'b0);
    @(negedge clk);
    chk("b2b_score0", dut_score(0), 8);
    chk("b2b_score1", dut_score(1), 0);
    for (int i = 0; i < 30; i++) begin
      image('0, '0, int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) setin(1'($urandom), 1'b1, IN_W'($urandom), rand_w());
    end
    repeat (3) setin(1'b0, 1'b0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
